// File: rtl/bsr_meta_store.sv
// BSR metadata store: loads a validated row_ptr/col_idx image from a word stream
// and answers scheduler reads with a fixed one-cycle latency.
module bsr_meta_store #(
  parameter int PTR_DEPTH = 128,
  parameter int COL_BASE  = 128,
  parameter int COL_DEPTH = 1024,
  parameter int N_W       = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [31:0]    s_data,
  input  logic           s_last,
  input  logic [N_W-1:0] NT,
  input  logic           clear,
  input  logic           meta_ren,
  input  logic [31:0]    meta_raddr,
  output logic           meta_ready,
  output logic [31:0]    meta_rdata,
  output logic           meta_rvalid,
  output logic           table_valid,
  output logic           load_err,
  output logic [2:0]     err_code,
  output logic           rd_oob
);

  localparam int PA_W  = $clog2(PTR_DEPTH);
  localparam int CA_W  = $clog2(COL_DEPTH);
  localparam int CNT_W = (PA_W > CA_W) ? PA_W : CA_W;

  typedef enum logic [2:0] {S_IDLE, S_HDR_NNZ, S_PTR, S_COL, S_DONE, S_ERR} state_t;
  typedef enum logic [2:0] {
    E_NONE, E_KT, E_NNZ, E_PTR, E_COL, E_EARLY, E_MISSING
  } err_t;

  state_t           state;
  err_t             err_q, chk_code, beat_code;
  logic [PA_W-1:0]  kt_q;
  logic [CA_W:0]    nnz_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      prev_q;
  logic             img_end, ptr_last, col_last;

  logic [31:0] row_mem [PTR_DEPTH];
  logic [31:0] col_mem [COL_DEPTH];

  assign s_ready    = (state != S_DONE);
  assign meta_ready = table_valid && (state == S_IDLE);
  assign err_code   = err_q;

  assign ptr_last = (32'(cnt_q) == 32'(kt_q));
  assign col_last = (32'(cnt_q) + 32'd1 == 32'(nnz_q));

  // Classify the current beat: content errors take priority over framing errors.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    chk_code = E_NONE;
    img_end  = 1'b0;
    case (state)
      S_IDLE:    if (s_data == 32'd0 || s_data > 32'(PTR_DEPTH - 1)) chk_code = E_KT;
      S_HDR_NNZ: if (s_data > 32'(COL_DEPTH)) chk_code = E_NNZ;
      S_PTR: begin
        if ((cnt_q == '0 && s_data != 32'd0) ||
            (cnt_q != '0 && s_data < prev_q) ||
            (ptr_last && s_data != 32'(nnz_q))) chk_code = E_PTR;
        img_end = ptr_last && (nnz_q == '0);
      end
      S_COL: begin
        if (s_data >= 32'(NT)) chk_code = E_COL;
        img_end = col_last;
      end
      default: ;
    endcase
    beat_code = chk_code;
    if (chk_code == E_NONE) begin
      if (img_end && !s_last)      beat_code = E_MISSING;
      else if (!img_end && s_last) beat_code = E_EARLY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      table_valid <= 1'b0;
      load_err    <= 1'b0;
      err_q       <= E_NONE;
      kt_q        <= '0;
      nnz_q       <= '0;
      cnt_q       <= '0;
      prev_q      <= '0;
    end else if (clear) begin
      state       <= S_IDLE;
      table_valid <= 1'b0;
      load_err    <= 1'b0;
      err_q       <= E_NONE;
    end else if (state == S_DONE) begin
      table_valid <= 1'b1;
      state       <= S_IDLE;
    end else if (s_valid) begin
      if (state == S_ERR) begin
        if (s_last) state <= S_IDLE;
      end else begin
        // NOTE: the header resets the flags and a header error sets them again in the
        // same cycle; with non-blocking assignments the later assignment wins.
        if (state == S_IDLE) begin
          table_valid <= 1'b0;
          load_err    <= 1'b0;
          err_q       <= E_NONE;
          kt_q        <= s_data[PA_W-1:0];
        end
        if (beat_code != E_NONE) begin
          load_err <= 1'b1;
          err_q    <= beat_code;
          state    <= s_last ? S_IDLE : S_ERR;
        end else begin
          case (state)
            S_IDLE: state <= S_HDR_NNZ;
            S_HDR_NNZ: begin
              nnz_q <= s_data[CA_W:0];
              cnt_q <= '0;
              state <= S_PTR;
            end
            S_PTR: begin
              prev_q <= s_data;
              if (img_end) state <= S_DONE;
              else if (ptr_last) begin
                cnt_q <= '0;
                state <= S_COL;
              end else cnt_q <= cnt_q + CNT_W'(1);
            end
            S_COL: begin
              if (img_end) state <= S_DONE;
              else cnt_q <= cnt_q + CNT_W'(1);
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  // NOTE: table storage has no reset; contents only matter once table_valid is set.
  always_ff @(posedge clk) begin
    if (s_valid && !clear) begin
      if (state == S_PTR) row_mem[cnt_q[PA_W-1:0]] <= s_data;
      if (state == S_COL) col_mem[cnt_q[CA_W-1:0]] <= s_data;
    end
  end

  logic        rd_acc, rd_in_ptr, rd_in_col;
  logic [31:0] col_off, rd_word;

  assign rd_acc    = meta_ren && meta_ready && !clear;
  assign col_off   = meta_raddr - 32'(COL_BASE);
  assign rd_in_ptr = meta_raddr < 32'(kt_q) + 32'd1;
  assign rd_in_col = (meta_raddr >= 32'(COL_BASE)) && (col_off < 32'(nnz_q));
  assign rd_word   = rd_in_ptr ? row_mem[meta_raddr[PA_W-1:0]] :
                     rd_in_col ? col_mem[col_off[CA_W-1:0]] : 32'd0;

  // Read data is held between responses; clear does not cut a response short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_rvalid <= 1'b0;
      meta_rdata  <= '0;
      rd_oob      <= 1'b0;
    end else begin
      meta_rvalid <= rd_acc;
      if (rd_acc) begin
        meta_rdata <= rd_word;
        if (!rd_in_ptr && !rd_in_col) rd_oob <= 1'b1;
      end
      if (clear) rd_oob <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bsr_meta_store.sv
// Bench for bsr_meta_store: packet-level reference model checked every cycle,
// plus directed loads/reads with hand-computed expectations.
module tb_bsr_meta_store;
  localparam int PTR_DEPTH = 128;
  localparam int COL_BASE  = 128;
  localparam int COL_DEPTH = 1024;
  localparam int N_W       = 10;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           s_valid = 1'b0, s_last = 1'b0, clear = 1'b0, meta_ren = 1'b0;
  logic [31:0]    s_data = '0, meta_raddr = '0;
  logic [N_W-1:0] nt = N_W'(8);
  logic           s_ready, meta_ready, meta_rvalid, table_valid, load_err, rd_oob;
  logic [31:0]    meta_rdata;
  logic [2:0]     err_code;

  bsr_meta_store #(.PTR_DEPTH(PTR_DEPTH), .COL_BASE(COL_BASE), .COL_DEPTH(COL_DEPTH), .N_W(N_W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .NT(nt), .clear(clear), .meta_ren(meta_ren), .meta_raddr(meta_raddr),
    .meta_ready(meta_ready), .meta_rdata(meta_rdata), .meta_rvalid(meta_rvalid),
    .table_valid(table_valid), .load_err(load_err), .err_code(err_code), .rd_oob(rd_oob)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (packet level) ----------------
  // mode: 0 idle, 1 collecting image, 2 draining after error, 3 image complete (one busy cycle)
  int          m_mode;
  logic [31:0] pkt[$];
  logic [31:0] m_row [PTR_DEPTH];
  logic [31:0] m_col [COL_DEPTH];
  int          m_kt, m_nnz, v_m;
  bit          m_tv, m_err, m_oob, m_rvalid;
  logic [2:0]  m_code;
  logic [31:0] m_rdata;

  // Judge the words collected so far: -1 incomplete, 0 complete and legal, >0 error code.
  function automatic int verdict(input logic [31:0] ntv);
    int n, kt, nnz;
    n  = pkt.size();
    kt = int'(pkt[0]);
    if (pkt[0] == 0 || pkt[0] > PTR_DEPTH - 1) return 1;
    if (n < 2) return -1;
    if (pkt[1] > COL_DEPTH) return 2;
    nnz = int'(pkt[1]);
    for (int i = 0; i <= kt && 2 + i < n; i++) begin
      if (i == 0 && pkt[2] != 0) return 3;
      if (i > 0 && pkt[2 + i] < pkt[1 + i]) return 3;
      if (i == kt && pkt[2 + i] != pkt[1]) return 3;
    end
    for (int j = 0; j < nnz && 3 + kt + j < n; j++)
      if (pkt[3 + kt + j] >= ntv) return 4;
    if (n == 3 + kt + nnz) return 0;
    return -1;
  endfunction

  task automatic model_fail(input int code);
    m_err  = 1'b1;
    m_code = 3'(code);
    m_mode = s_last ? 0 : 2;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; pkt.delete(); m_tv = 0; m_err = 0; m_code = '0;
      m_oob = 0; m_rvalid = 0; m_rdata = '0;
    end else if (clear) begin
      m_mode = 0; m_tv = 0; m_err = 0; m_code = '0; m_oob = 0; m_rvalid = 0;
    end else begin
      m_rvalid = meta_ren && m_tv && (m_mode == 0);
      if (m_rvalid) begin
        if (meta_raddr <= 32'(m_kt)) m_rdata = m_row[int'(meta_raddr)];
        else if (meta_raddr >= COL_BASE && meta_raddr < 32'(COL_BASE + m_nnz))
          m_rdata = m_col[int'(meta_raddr) - COL_BASE];
        else begin
          m_rdata = '0;
          m_oob   = 1'b1;
        end
      end
      if (m_mode == 3) begin
        m_kt  = int'(pkt[0]);
        m_nnz = int'(pkt[1]);
        for (int i = 0; i <= m_kt; i++) m_row[i] = pkt[2 + i];
        for (int j = 0; j < m_nnz; j++) m_col[j] = pkt[3 + m_kt + j];
        m_tv   = 1'b1;
        m_mode = 0;
      end else if (s_valid) begin
        if (m_mode == 2) begin
          if (s_last) m_mode = 0;
        end else begin
          if (m_mode == 0) begin
            pkt.delete(); m_tv = 0; m_err = 0; m_code = '0; m_mode = 1;
          end
          pkt.push_back(s_data);
          v_m = verdict(32'(nt));
          if (v_m > 0)                  model_fail(v_m);
          else if (v_m == 0 && !s_last) model_fail(6);
          else if (v_m < 0 && s_last)   model_fail(5);
          else if (v_m == 0)            m_mode = 3;
        end
      end
    end
  end

  // Compare process: every cycle out of reset, on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cyc_rvalid", 32'(meta_rvalid), 32'(m_rvalid));
      check("cyc_rdata", meta_rdata, m_rdata);
      check("cyc_table_valid", 32'(table_valid), 32'(m_tv));
      check("cyc_load_err", 32'(load_err), 32'(m_err));
      check("cyc_err_code", 32'(err_code), 32'(m_code));
      check("cyc_rd_oob", 32'(rd_oob), 32'(m_oob));
      check("cyc_meta_ready", 32'(meta_ready), 32'(m_tv && m_mode == 0));
      check("cyc_s_ready", 32'(s_ready), 32'(m_mode != 3));
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] img[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_img(input bit with_last);
    for (int i = 0; i < img.size(); i++) begin
      s_valid = 1'b1;
      s_data  = img[i];
      s_last  = with_last && (i == img.size() - 1);
      step();
      meta_ren = 1'b0;
    end
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] e, input string nm);
    meta_ren = 1'b1; meta_raddr = a;
    step();
    meta_ren = 1'b0;
    check({nm, "_data"}, meta_rdata, e);
    check({nm, "_rvalid"}, 32'(meta_rvalid), 32'd1);
    step();
    check({nm, "_rvalid_drop"}, 32'(meta_rvalid), 32'd0);
  endtask

  task automatic check_err(input string nm, input logic le, input logic [2:0] code);
    check({nm, "_load_err"}, 32'(load_err), 32'(le));
    check({nm, "_err_code"}, 32'(err_code), 32'(code));
  endtask

  logic [31:0] bb_exp [4];

  initial begin
    bb_exp = '{32'd0, 32'd1, 32'd3, 32'd0};
    step(); step();
    check("rst_table_valid", 32'(table_valid), 0);
    check("rst_meta_rvalid", 32'(meta_rvalid), 0);
    check("rst_meta_rdata", meta_rdata, 0);
    check("rst_meta_ready", 32'(meta_ready), 0);
    check_err("rst", 1'b0, 3'd0);
    check("rst_rd_oob", 32'(rd_oob), 0);
    rst_n = 1'b1;
    step();

    // Valid image KT=2 nnz=3, then single reads
    img = '{2, 3, 0, 1, 3, 4, 0, 7};
    send_img(1'b1);
    check("done_cycle_tv", 32'(table_valid), 0);
    check("done_cycle_s_ready", 32'(s_ready), 0);
    step();
    check("load1_tv", 32'(table_valid), 1);
    check("load1_meta_ready", 32'(meta_ready), 1);
    rd_chk(0, 0, "rd0");
    rd_chk(1, 1, "rd1");
    rd_chk(2, 3, "rd2");
    rd_chk(128, 4, "rd128");
    rd_chk(130, 7, "rd130");
    check("rd_oob_clean", 32'(rd_oob), 0);

    // Back-to-back reads 0..3; address 3 is unmapped
    meta_ren = 1'b1;
    for (int i = 0; i < 4; i++) begin
      meta_raddr = 32'(i);
      step();
      check("b2b_rvalid", 32'(meta_rvalid), 1);
      check("b2b_data", meta_rdata, bb_exp[i]);
    end
    meta_ren = 1'b0;
    step();
    check("b2b_rvalid_end", 32'(meta_rvalid), 0);
    check("b2b_hold", meta_rdata, 0);
    check("b2b_oob", 32'(rd_oob), 1);

    // Read coincident with a new header: answered from the old table
    meta_ren = 1'b1; meta_raddr = 2;
    img = '{2, 3, 0, 2, 1, 4, 0, 7};
    send_img(1'b1);
    check("hdr_read_old_data", meta_rdata, 3);
    check_err("ptr_nonmono", 1'b1, 3'd3);
    check("ptr_nonmono_ready", 32'(meta_ready), 0);
    meta_ren = 1'b1; meta_raddr = 0;
    step();
    meta_ren = 1'b0;
    check("ignored_read", 32'(meta_rvalid), 0);

    // col_idx == NT, then a good image clears the error
    img = '{2, 3, 0, 1, 3, 4, 8, 7};
    send_img(1'b1);
    check_err("col_ge_nt", 1'b1, 3'd4);
    img = '{1, 2, 0, 2, 5, 6};
    send_img(1'b1);
    step();
    check_err("reload", 1'b0, 3'd0);
    check("reload_tv", 32'(table_valid), 1);
    rd_chk(129, 6, "reload_rd129");

    // Framing errors and header limits
    img = '{2, 3, 0, 1};
    send_img(1'b1);
    check_err("early_last", 1'b1, 3'd5);
    check("early_last_idle", 32'(s_ready), 1);
    img = '{2, 3, 0, 1, 3, 4, 0, 7};
    send_img(1'b0);
    check_err("missing_last", 1'b1, 3'd6);
    img = '{9, 9};
    send_img(1'b1);
    check_err("missing_last_drained", 1'b1, 3'd6);
    img = '{128, 5};
    send_img(1'b1);
    check_err("kt_too_big", 1'b1, 3'd1);
    img = '{1, 1025, 0};
    send_img(1'b1);
    check_err("nnz_too_big", 1'b1, 3'd2);
    img.delete();
    img.push_back(127); img.push_back(0);
    for (int i = 0; i < 128; i++) img.push_back(0);
    send_img(1'b1);
    step();
    check("kt_max_tv", 32'(table_valid), 1);
    rd_chk(127, 0, "kt_max_rd127");

    // Clear, then empty matrix
    clear = 1'b1; step(); clear = 1'b0;
    check("clear_tv", 32'(table_valid), 0);
    check("clear_oob", 32'(rd_oob), 0);
    img = '{1, 0, 0, 0};
    send_img(1'b1);
    step();
    check("empty_tv", 32'(table_valid), 1);
    rd_chk(0, 0, "empty_rd0");
    rd_chk(1, 0, "empty_rd1");
    check("empty_no_oob", 32'(rd_oob), 0);
    rd_chk(128, 0, "empty_rd128");
    check("empty_oob", 32'(rd_oob), 1);

    // Clear mid-load, reset mid-load, then a clean reload
    s_valid = 1'b1; s_data = 2; step(); s_data = 3; step();
    clear = 1'b1; s_valid = 1'b0; step(); clear = 1'b0;
    s_valid = 1'b1; s_data = 2; step(); s_data = 3; step(); s_data = 0; step();
    rst_n = 1'b0; s_valid = 1'b0;
    #1;
    check("midrst_tv", 32'(table_valid), 0);
    check_err("midrst", 1'b0, 3'd0);
    check("midrst_rvalid", 32'(meta_rvalid), 0);
    check("midrst_rdata", meta_rdata, 0);
    check("midrst_oob", 32'(rd_oob), 0);
    step();
    rst_n = 1'b1;
    step();
    img = '{2, 3, 0, 1, 3, 4, 0, 7};
    send_img(1'b1);
    step();
    rd_chk(130, 7, "post_rst_rd130");
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
